apb_timer: RTL and testbench
============================

Name: apb_timer

Overview:
APB4 slave timer peripheral that sits directly downstream of the ahb3lite-to-APB bridge on the SoC peripheral bus. It provides a prescaled 32-bit up-counter, a compare register and a level interrupt for the RISC-V core. The block is a zero-wait-state slave. It reports PSLVERR on unmapped addresses.

Parameters:
PADDR_SIZE, 10, APB address width; only PADDR[4:2] is decoded, upper bits ignored
PDATA_SIZE, 32, APB data width; only 32 is supported
PRESCALE_SIZE, 16, width of the prescaler register and prescaler counter

Ports:
PRESETn  input  1  asynchronous active-low reset
PCLK  input  1  single clock for bus and timer logic
PSEL  input  1  slave select
PENABLE  input  1  access phase
PPROT  input  3  protection; bit0=1 means privileged
PWRITE  input  1  1=write
PSTRB  input  PDATA_SIZE/8  write byte strobes
PADDR  input  PADDR_SIZE  byte address
PWDATA  input  PDATA_SIZE  write data
PRDATA  output  PDATA_SIZE  read data
PREADY  output  1  transfer complete
PSLVERR  output  1  transfer error
IRQ  output  1  timer interrupt, level, active-high

Behaviour:
- Clock and reset: one clock PCLK; PRESETn is asynchronous and active-low. All state clears on reset.
- Reset values: all registers 0, IRQ=0, PRDATA=0, PSLVERR=0, PREADY=1.
- Register map (offset):
  - 0x00 CTRL: bit0 EN, bit1 IE, bit2 AUTO; other bits read 0.
  - 0x04 PRESCALE: PRESCALE_SIZE bits.
  - 0x08 COUNT: 32 bits, RW.
  - 0x0C COMPARE: 32 bits.
  - 0x10 STATUS: bit0 PEND, write-1-to-clear.
  - 0x14-0x1C: unmapped.
- Access:
  - A transfer completes in the cycle where PSEL&PENABLE is high. PREADY is constant 1.
  - A write takes effect at that edge, per byte lane enabled by PSTRB.
  - PRDATA is driven combinationally from the addressed register whenever PSEL is high, and is 0 otherwise.
  - PSLVERR is high only when PSEL&PENABLE is high and the address is unmapped. Unmapped writes change no state; unmapped reads return 0.
- Prescaler (internal pcnt):
  - While EN=1: pcnt increments each cycle. When pcnt==PRESCALE, pcnt<=0 and a tick fires. PRESCALE=0 therefore gives a tick every cycle.
  - While EN=0: pcnt is held at 0 and no ticks fire.
  - A write to PRESCALE clears pcnt.
- Counter, on each tick:
  - If COUNT==COMPARE: PEND<=1. If AUTO=1, COUNT<=0; otherwise COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1.
  - Wrap from 0xFFFF_FFFF to 0 is silent and sets no flag.
- IRQ: registered, IRQ<=PEND&IE, i.e. 1 cycle after PEND/IE change.
- Simultaneous events:
  - An APB write to COUNT in a tick cycle wins; the tick increment is lost.
  - W1C of PEND in the same cycle as a new match: set wins, PEND stays 1.
  - A write to COMPARE in a tick cycle: that tick compares against the old COMPARE value.
- Reset mid-transfer: all state clears immediately. The bus master re-issues the transfer.

Optional Feature:
- Macro: APB_TIMER_PROT_EN.
- Defined: a write with PPROT[0]=0 (non-privileged) to any mapped register is rejected with PSLVERR=1 and no state change. Non-privileged reads are allowed.
- Undefined: PPROT is ignored, and PSLVERR reflects unmapped addresses only.

Test Plan:
- Reset release, read all 5 registers -> all read 0, PSLVERR=0, IRQ=0.
- Write PRESCALE=3, COMPARE=2, CTRL=0x3 (EN, IE) -> COUNT increments every 4 cycles; PEND set on the tick where COUNT==2; IRQ high 1 cycle later; COUNT continues 3,4,...
- Same setup with CTRL=0x7 (AUTO) -> COUNT sequence 0,1,2,0,1,2; PEND set each time COUNT==2. Write STATUS=0x1 -> PEND=0, then IRQ=0 next cycle; PEND re-sets on the next match.
- Write COUNT=0xFFFF_FFFF, COMPARE=0x10, PRESCALE=0, EN=1 -> COUNT wraps to 0 with no PEND; PEND sets when COUNT==0x10.
- Write 0xAABBCCDD to COMPARE with PSTRB=4'b0101 from 0 -> COMPARE reads 0x00BB00DD. Access offset 0x18 -> PSLVERR=1, PRDATA=0, no register change.
- With APB_TIMER_PROT_EN: write CTRL=0x1 with PPROT=3'b000 -> PSLVERR=1, CTRL stays 0. Repeat with PPROT=3'b001 -> PSLVERR=0, CTRL=0x1.

Source files
------------

// File: rtl/apb_timer.sv
`default_nettype none
// ============================================================================
// Module      : apb_timer
// Description : APB4 zero-wait-state timer peripheral. A prescaler divides
//               PCLK into ticks that advance a 32-bit up-counter. When the
//               counter equals the compare register on a tick, the pending
//               flag is set. The registered level interrupt follows PEND & IE.
//
// Ports       : PRESETn  - asynchronous active-low reset
//               PCLK     - bus and timer clock
//               PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA
//                        - APB4 request (only PADDR[4:2] decoded)
//               PRDATA   - combinational read data (0 when PSEL low)
//               PREADY   - tied high (zero wait states)
//               PSLVERR  - unmapped access (or rejected write, see below)
//               IRQ      - level interrupt, active-high
//
// Registers   : 0x00 CTRL     {AUTO, IE, EN}
//               0x04 PRESCALE prescaler reload value
//               0x08 COUNT    counter value
//               0x0C COMPARE  match value
//               0x10 STATUS   bit0 PEND, write-1-to-clear
//               0x14-0x1C     unmapped
//
// Options     : APB_TIMER_PROT_EN - when defined, writes with PPROT[0]=0
//               are rejected with PSLVERR and change no state.
//
// Revision    : 1.0 - initial release
// ============================================================================

module apb_timer #(
  parameter int PADDR_SIZE    = 10,
  parameter int PDATA_SIZE    = 32,
  parameter int PRESCALE_SIZE = 16
) (
  input  logic                    PRESETn,
  input  logic                    PCLK,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [2:0]              PPROT,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic                    IRQ
);

  // Word index of each register (PADDR[4:2])
  localparam logic [2:0] c_IDX_CTRL     = 3'd0;
  localparam logic [2:0] c_IDX_PRESCALE = 3'd1;
  localparam logic [2:0] c_IDX_COUNT    = 3'd2;
  localparam logic [2:0] c_IDX_COMPARE  = 3'd3;
  localparam logic [2:0] c_IDX_STATUS   = 3'd4;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                     r_en;
  logic                     r_ie;
  logic                     r_auto;
  logic [PRESCALE_SIZE-1:0] r_prescale;
  logic [PRESCALE_SIZE-1:0] r_pcnt;
  logic [PDATA_SIZE-1:0]    r_count;
  logic [PDATA_SIZE-1:0]    r_compare;
  logic                     r_pend;
  logic                     r_irq;

  // --------------------------------------------------------------------------
  // Byte-lane merge of write data into an existing register value
  // --------------------------------------------------------------------------
  function automatic logic [PDATA_SIZE-1:0] f_merge(
    input logic [PDATA_SIZE-1:0]   old_val,
    input logic [PDATA_SIZE-1:0]   wdata,
    input logic [PDATA_SIZE/8-1:0] strb
  );
    logic [PDATA_SIZE-1:0] res;
    res = old_val;
    for (int b = 0; b < PDATA_SIZE/8; b++) begin
      if (strb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Address decode and access qualification
  // --------------------------------------------------------------------------
  logic       w_access;
  logic [2:0] w_idx;
  logic       w_mapped;
  logic       w_prot_fault;
  logic       w_err;
  logic       w_wr;
  logic       w_wr_ctrl;
  logic       w_wr_prescale;
  logic       w_wr_count;
  logic       w_wr_compare;
  logic       w_wr_status;

  assign w_access = PSEL & PENABLE;
  assign w_idx    = PADDR[4:2];
  assign w_mapped = (w_idx <= c_IDX_STATUS);

`ifdef APB_TIMER_PROT_EN
  // Non-privileged writes are refused; reads stay open to all masters.
  assign w_prot_fault = PWRITE & ~PPROT[0];
`else
  assign w_prot_fault = 1'b0;
`endif

  assign w_err = ~w_mapped | w_prot_fault;
  assign w_wr  = w_access & PWRITE & ~w_err;

  assign w_wr_ctrl     = w_wr & (w_idx == c_IDX_CTRL);
  assign w_wr_prescale = w_wr & (w_idx == c_IDX_PRESCALE);
  assign w_wr_count    = w_wr & (w_idx == c_IDX_COUNT);
  assign w_wr_compare  = w_wr & (w_idx == c_IDX_COMPARE);
  assign w_wr_status   = w_wr & (w_idx == c_IDX_STATUS);

  // Bits that are intentionally not decoded
  logic w_unused_bits;
  assign w_unused_bits = ^{PADDR[PADDR_SIZE-1:5], PADDR[1:0], PPROT};

  // --------------------------------------------------------------------------
  // Bus outputs
  // --------------------------------------------------------------------------
  assign PREADY  = 1'b1;
  assign PSLVERR = w_access & w_err;

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (w_idx)
        c_IDX_CTRL:     PRDATA = {{(PDATA_SIZE-3){1'b0}}, r_auto, r_ie, r_en};
        c_IDX_PRESCALE: PRDATA = PDATA_SIZE'(r_prescale);
        c_IDX_COUNT:    PRDATA = r_count;
        c_IDX_COMPARE:  PRDATA = r_compare;
        c_IDX_STATUS:   PRDATA = {{(PDATA_SIZE-1){1'b0}}, r_pend};
        default:        PRDATA = '0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Timer datapath
  // --------------------------------------------------------------------------
  logic                     w_tick;
  logic                     w_match;
  logic                     w_pend_clr;
  logic [PDATA_SIZE-1:0]    w_count_wr;
  logic [PDATA_SIZE-1:0]    w_compare_wr;
  logic [PRESCALE_SIZE-1:0] w_prescale_wr;

  // The tick and the match both use the values held before this edge, so
  // a COMPARE write in a tick cycle only affects later ticks.
  assign w_tick  = r_en & (r_pcnt == r_prescale);
  assign w_match = (r_count == r_compare);

  assign w_pend_clr    = w_wr_status & PSTRB[0] & PWDATA[0];
  assign w_count_wr    = f_merge(r_count, PWDATA, PSTRB);
  assign w_compare_wr  = f_merge(r_compare, PWDATA, PSTRB);
  assign w_prescale_wr = PRESCALE_SIZE'(f_merge(PDATA_SIZE'(r_prescale), PWDATA, PSTRB));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_en       <= 1'b0;
      r_ie       <= 1'b0;
      r_auto     <= 1'b0;
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_count    <= '0;
      r_compare  <= '0;
      r_pend     <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      // Control bits all live in byte lane 0
      if (w_wr_ctrl && PSTRB[0]) begin
        r_en   <= PWDATA[0];
        r_ie   <= PWDATA[1];
        r_auto <= PWDATA[2];
      end

      if (w_wr_prescale) r_prescale <= w_prescale_wr;
      if (w_wr_compare)  r_compare  <= w_compare_wr;

      // Prescaler restarts whenever the divider setting is touched
      if (!r_en || w_wr_prescale || w_tick) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end

      // A bus write to COUNT overrides the tick that would have advanced it
      if (w_wr_count) begin
        r_count <= w_count_wr;
      end else if (w_tick) begin
        if (w_match && r_auto) r_count <= '0;
        else                   r_count <= r_count + 1'b1;
      end

      // A new match beats a simultaneous write-1-to-clear
      r_pend <= (w_tick & w_match) | (r_pend & ~w_pend_clr);

      r_irq <= r_pend & r_ie;
    end
  end

  assign IRQ = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_apb_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_timer
// Description : Directed self-checking bench for apb_timer. Expected values
//               are hand-derived cycle positions relative to the edge at
//               which the enabling CTRL write lands.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_apb_timer;

  logic        PRESETn;
  logic        PCLK;
  logic        PSEL;
  logic        PENABLE;
  logic [2:0]  PPROT;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic [9:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        IRQ;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  localparam logic [9:0] A_CTRL  = 10'h000;
  localparam logic [9:0] A_PRE   = 10'h004;
  localparam logic [9:0] A_COUNT = 10'h008;
  localparam logic [9:0] A_CMP   = 10'h00C;
  localparam logic [9:0] A_STAT  = 10'h010;

  apb_timer #(
    .PADDR_SIZE   (10),
    .PDATA_SIZE   (32),
    .PRESCALE_SIZE(16)
  ) dut (
    .PRESETn(PRESETn),
    .PCLK   (PCLK),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PPROT  (PPROT),
    .PWRITE (PWRITE),
    .PSTRB  (PSTRB),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .IRQ    (IRQ)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // One APB transfer; called just after a clock edge. The access-phase
  // samples see the state left by the first edge; a write lands on the second.
  task automatic apb_xfer(input logic wr, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot,
                          output logic [31:0] rdata, output logic err, output logic rdy);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = wdata; PSTRB = strb; PPROT = prot;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    rdata = PRDATA; err = PSLVERR; rdy = PREADY;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'h0;
  endtask

  task automatic wr(input logic [9:0] addr, input logic [31:0] data);
    logic [31:0] d; logic e; logic r;
    apb_xfer(1'b1, addr, data, 4'hF, 3'b001, d, e, r);
  endtask

  task automatic rd(input logic [9:0] addr, output logic [31:0] data);
    logic e; logic r;
    apb_xfer(1'b0, addr, 32'h0, 4'h0, 3'b001, data, e, r);
  endtask

  // Read so that the sampled value is the state right after edge `target`.
  task automatic rd_at(input int target, input logic [9:0] addr, output logic [31:0] data);
    if (cyc > target - 1) begin
      n_total++;
      $display("FAIL rd_at_sched: cycle %0d already past required start %0d", cyc, target - 1);
    end
    while (cyc < target - 1) begin
      @(posedge PCLK); #1;
    end
    rd(addr, data);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d; logic e; logic r;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PPROT = 3'b001; PSTRB = 4'h0; PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge PCLK);
    #1;
    n_total++;
    if (IRQ !== 1'b0 || PREADY !== 1'b1 || PSLVERR !== 1'b0 || PRDATA !== 32'h0)
      $display("FAIL reset_outputs: got IRQ=%b PREADY=%b PSLVERR=%b PRDATA=%h required 0/1/0/0",
               IRQ, PREADY, PSLVERR, PRDATA);
    else n_pass++;
    PRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apb_xfer(1'b0, 10'(i * 4), 32'h0, 4'h0, 3'b001, d, e, r);
      n_total++;
      if (d !== 32'h0 || e !== 1'b0)
        $display("FAIL reset_reg%0d: got data=%h err=%b required 0/0", i, d, e);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; int w;
    wr(A_PRE, 32'd3);
    wr(A_CMP, 32'd2);
    wr(A_CTRL, 32'h3);
    w = cyc;
    rd_at(w + 4, A_COUNT, d);
    n_total++; if (d !== 32'd1) $display("FAIL basic_count1: got %h required 1", d); else n_pass++;
    rd_at(w + 8, A_COUNT, d);
    n_total++; if (d !== 32'd2) $display("FAIL basic_count2: got %h required 2", d); else n_pass++;
    rd_at(w + 11, A_STAT, d);
    n_total++; if (d !== 32'd0) $display("FAIL basic_pend_early: got %h required 0", d); else n_pass++;
    n_total++; if (IRQ !== 1'b0) $display("FAIL basic_irq_early: got %b required 0", IRQ); else n_pass++;
    rd_at(w + 13, A_STAT, d);
    n_total++; if (d !== 32'd1) $display("FAIL basic_pend: got %h required 1", d); else n_pass++;
    n_total++; if (IRQ !== 1'b1) $display("FAIL basic_irq: got %b required 1", IRQ); else n_pass++;
    rd_at(w + 17, A_COUNT, d);
    n_total++; if (d !== 32'd4) $display("FAIL basic_count4: got %h required 4", d); else n_pass++;
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_auto();
    logic [31:0] d; int w;
    wr(A_COUNT, 32'h0);
    wr(A_STAT, 32'h1);
    wr(A_CTRL, 32'h7);
    w = cyc;
    rd_at(w + 8, A_COUNT, d);
    n_total++; if (d !== 32'd2) $display("FAIL auto_count2: got %h required 2", d); else n_pass++;
    rd_at(w + 12, A_COUNT, d);
    n_total++; if (d !== 32'd0) $display("FAIL auto_reload: got %h required 0", d); else n_pass++;
    rd_at(w + 14, A_STAT, d);
    n_total++; if (d !== 32'd1) $display("FAIL auto_pend: got %h required 1", d); else n_pass++;
    n_total++; if (IRQ !== 1'b1) $display("FAIL auto_irq: got %b required 1", IRQ); else n_pass++;
    wr(A_STAT, 32'h1);  // lands on edge w+17
    n_total++; if (IRQ !== 1'b1) $display("FAIL auto_irq_lag: got %b required 1", IRQ); else n_pass++;
    rd_at(w + 18, A_STAT, d);
    n_total++; if (d !== 32'd0) $display("FAIL auto_w1c: got %h required 0", d); else n_pass++;
    n_total++; if (IRQ !== 1'b0) $display("FAIL auto_irq_clr: got %b required 0", IRQ); else n_pass++;
    rd_at(w + 20, A_COUNT, d);
    n_total++; if (d !== 32'd2) $display("FAIL auto_count_again: got %h required 2", d); else n_pass++;
    rd_at(w + 24, A_STAT, d);
    n_total++; if (d !== 32'd1) $display("FAIL auto_pend_again: got %h required 1", d); else n_pass++;
    rd_at(w + 26, A_COUNT, d);
    n_total++; if (d !== 32'd0) $display("FAIL auto_reload_again: got %h required 0", d); else n_pass++;
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_wrap();
    logic [31:0] d; int w;
    wr(A_STAT, 32'h1);
    wr(A_PRE, 32'h0);
    wr(A_CMP, 32'h10);
    wr(A_COUNT, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    w = cyc;
    rd_at(w + 1, A_COUNT, d);
    n_total++; if (d !== 32'h0) $display("FAIL wrap_count: got %h required 0", d); else n_pass++;
    rd_at(w + 3, A_STAT, d);
    n_total++; if (d !== 32'h0) $display("FAIL wrap_no_pend: got %h required 0", d); else n_pass++;
    rd_at(w + 15, A_STAT, d);
    n_total++; if (d !== 32'h0) $display("FAIL wrap_pend_early: got %h required 0", d); else n_pass++;
    rd_at(w + 17, A_COUNT, d);
    n_total++; if (d !== 32'h10) $display("FAIL wrap_count_10: got %h required 10", d); else n_pass++;
    rd_at(w + 19, A_STAT, d);
    n_total++; if (d !== 32'h1) $display("FAIL wrap_pend: got %h required 1", d); else n_pass++;
    n_total++; if (IRQ !== 1'b0) $display("FAIL wrap_irq_masked: got %b required 0", IRQ); else n_pass++;
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; int w;
    // COUNT write in a tick cycle: the tick increment is lost
    wr(A_CTRL, 32'h1);
    wr(A_COUNT, 32'h100);
    rd(A_COUNT, d);
    n_total++; if (d !== 32'h101) $display("FAIL b2b_count_wins: got %h required 101", d); else n_pass++;
    wr(A_CTRL, 32'h0);
    // W1C in the same cycle as a new match: set wins
    wr(A_COUNT, 32'h0E);
    wr(A_STAT, 32'h1);
    wr(A_CTRL, 32'h1);
    w = cyc;
    @(posedge PCLK); #1;
    wr(A_STAT, 32'h1);  // lands on edge w+3, the matching tick
    rd(A_STAT, d);
    n_total++; if (d !== 32'h1) $display("FAIL b2b_set_wins: got %h required 1 (w=%0d)", d, w); else n_pass++;
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_strobe_unmapped();
    logic [31:0] d; logic e; logic r;
    wr(A_CMP, 32'h0);
    apb_xfer(1'b1, A_CMP, 32'hAABB_CCDD, 4'b0101, 3'b001, d, e, r);
    n_total++; if (e !== 1'b0 || r !== 1'b1) $display("FAIL strb_err: got err=%b ready=%b required 0/1", e, r); else n_pass++;
    rd(A_CMP, d);
    n_total++; if (d !== 32'h00BB_00DD) $display("FAIL strb_compare: got %h required 00bb00dd", d); else n_pass++;
    apb_xfer(1'b1, 10'h018, 32'hFFFF_FFFF, 4'hF, 3'b001, d, e, r);
    n_total++; if (e !== 1'b1) $display("FAIL unmapped_wr_err: got %b required 1", e); else n_pass++;
    apb_xfer(1'b0, 10'h018, 32'h0, 4'h0, 3'b001, d, e, r);
    n_total++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL unmapped_rd: got err=%b data=%h required 1/0", e, d); else n_pass++;
    apb_xfer(1'b0, 10'h014, 32'h0, 4'h0, 3'b001, d, e, r);
    n_total++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL unmapped_14: got err=%b data=%h required 1/0", e, d); else n_pass++;
    rd(A_CMP, d);
    n_total++; if (d !== 32'h00BB_00DD) $display("FAIL unmapped_nochange: got %h required 00bb00dd", d); else n_pass++;
    apb_xfer(1'b0, A_CTRL, 32'h0, 4'h0, 3'b001, d, e, r);
    n_total++; if (e !== 1'b0 || d !== 32'h0) $display("FAIL ctrl_intact: got err=%b data=%h required 0/0", e, d); else n_pass++;
  endtask

`ifdef APB_TIMER_PROT_EN
  task automatic test_prot();
    logic [31:0] d; logic e; logic r;
    apb_xfer(1'b1, A_CTRL, 32'h1, 4'hF, 3'b000, d, e, r);
    n_total++; if (e !== 1'b1) $display("FAIL prot_reject_err: got %b required 1", e); else n_pass++;
    apb_xfer(1'b0, A_CTRL, 32'h0, 4'h0, 3'b000, d, e, r);
    n_total++; if (e !== 1'b0 || d !== 32'h0) $display("FAIL prot_reject_state: got err=%b data=%h required 0/0", e, d); else n_pass++;
    apb_xfer(1'b1, A_CTRL, 32'h1, 4'hF, 3'b001, d, e, r);
    n_total++; if (e !== 1'b0) $display("FAIL prot_accept_err: got %b required 0", e); else n_pass++;
    rd(A_CTRL, d);
    n_total++; if (d !== 32'h1) $display("FAIL prot_accept_state: got %h required 1", d); else n_pass++;
    wr(A_CTRL, 32'h0);
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(A_CMP, 32'h55);
    wr(A_CTRL, 32'h2);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_CMP;
    PWDATA = 32'h77; PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    PRESETn = 1'b0;
    #1;
    n_total++; if (PRDATA !== 32'h0) $display("FAIL mid_reset_prdata: got %h required 0", PRDATA); else n_pass++;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'h0;
    PRESETn = 1'b1;
    rd(A_CMP, d);
    n_total++; if (d !== 32'h0) $display("FAIL mid_reset_compare: got %h required 0", d); else n_pass++;
    rd(A_CTRL, d);
    n_total++; if (d !== 32'h0) $display("FAIL mid_reset_ctrl: got %h required 0", d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_auto();
    test_wrap();
    test_back_to_back();
    test_strobe_unmapped();
`ifdef APB_TIMER_PROT_EN
    test_prot();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
